result_bus_arbiter: RTL and testbench

Shares the single writeback/result bus among the fixed-point execution units fed by the dispatcher (add_sub, mul, div, log, rot, cmp, sys, trap). Each unit offers a finished result tagged with its reservation-station ID. The arbiter grants one unit per cycle using a round-robin policy and registers the winner into a one-entry output stage. The register file, CR/XER update logic and reservation-station wake-up consume that stage through a valid/ready handshake.

---
 rtl/result_bus_if.sv | 42 ++++
 rtl/result_bus_arbiter.sv | 104 ++++++++++
 tb/tb_result_bus_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/result_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : result_bus_if
// Function : Result bus that links the execution-unit offers, the arbiter
//            and the writeback consumer.
// Revision : 1.0  initial release
// ============================================================================
interface result_bus_if #(
   parameter int NUM_UNITS   = 8,
   parameter int RS_ID_WIDTH = 5,
   parameter int DATA_WIDTH  = 32
);
   localparam int c_UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   // Unit side: bit/slice k belongs to unit k, and unit 0 is the leftmost bit.
   logic [0:NUM_UNITS-1]             unit_valid;
   logic [0:NUM_UNITS-1]             unit_ready;
   logic [0:NUM_UNITS*RS_ID_WIDTH-1] unit_id;
   logic [0:NUM_UNITS*DATA_WIDTH-1]  unit_result;
   logic [0:NUM_UNITS*4-1]           unit_cr;
   logic [0:NUM_UNITS*3-1]           unit_xer;

   // Writeback side.
   logic                   out_valid;
   logic                   out_ready;
   logic [RS_ID_WIDTH-1:0] out_id;
   logic [DATA_WIDTH-1:0]  out_result;
   logic [3:0]             out_cr;
   logic [2:0]             out_xer;
   logic [c_UNIT_W-1:0]    out_unit;

   modport master (
      input  unit_valid, unit_id, unit_result, unit_cr, unit_xer, out_ready,
      output unit_ready, out_valid, out_id, out_result, out_cr, out_xer, out_unit
   );

   modport slave (
      output unit_valid, unit_id, unit_result, unit_cr, unit_xer, out_ready,
      input  unit_ready, out_valid, out_id, out_result, out_cr, out_xer, out_unit
   );
endinterface
`default_nettype wire

// File: rtl/result_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : result_bus_arbiter
// Function : Round-robin arbiter that moves one execution-unit result per
//            cycle onto the shared writeback bus through a one-entry stage.
// Revision : 1.0  initial release
// ============================================================================
module result_bus_arbiter #(
   parameter int NUM_UNITS   = 8,
   parameter int RS_ID_WIDTH = 5,
   parameter int DATA_WIDTH  = 32
) (
   input  wire logic     clk,
   input  wire logic     rst,
   result_bus_if.master  bus
);
   localparam int c_UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam logic [c_UNIT_W-1:0] c_LAST_RESET = c_UNIT_W'(NUM_UNITS - 1);

   logic                   r_out_valid;
   logic [RS_ID_WIDTH-1:0] r_out_id;
   logic [DATA_WIDTH-1:0]  r_out_result;
   logic [3:0]             r_out_cr;
   logic [2:0]             r_out_xer;
   logic [c_UNIT_W-1:0]    r_out_unit;
   logic [c_UNIT_W-1:0]    r_last;

   logic                   w_load_en;
   logic                   w_found;
   logic                   w_grant;
   logic [c_UNIT_W-1:0]    w_win;
   logic [0:NUM_UNITS-1]   w_ready;
   logic [RS_ID_WIDTH-1:0] w_sel_id;
   logic [DATA_WIDTH-1:0]  w_sel_result;
   logic [3:0]             w_sel_cr;
   logic [2:0]             w_sel_xer;

   assign w_load_en = ~r_out_valid | bus.out_ready;

   // Walk from last+1 with wrap; the unit at last is visited last.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 1; i <= NUM_UNITS; i++) begin
         int idx;
         idx = (int'(r_last) + i) % NUM_UNITS;
         if (!w_found && bus.unit_valid[c_UNIT_W'(idx)]) begin
            w_found = 1'b1;
            w_win   = c_UNIT_W'(idx);
         end
      end
   end

   // Reset gating keeps a unit from believing a transfer happened while rst is high.
   assign w_grant = w_load_en & w_found & ~rst;

   always_comb begin
      w_ready = '0;
      if (w_grant) begin
         w_ready[w_win] = 1'b1;
      end
   end

   always_comb begin
      w_sel_id     = bus.unit_id[int'(w_win)*RS_ID_WIDTH +: RS_ID_WIDTH];
      w_sel_result = bus.unit_result[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
      w_sel_cr     = bus.unit_cr[int'(w_win)*4 +: 4];
      w_sel_xer    = bus.unit_xer[int'(w_win)*3 +: 3];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_id     <= '0;
         r_out_result <= '0;
         r_out_cr     <= '0;
         r_out_xer    <= '0;
         r_out_unit   <= '0;
         r_last       <= c_LAST_RESET;
      end else if (w_load_en) begin
         if (w_found) begin
            r_out_valid  <= 1'b1;
            r_out_id     <= w_sel_id;
            r_out_result <= w_sel_result;
            r_out_cr     <= w_sel_cr;
            r_out_xer    <= w_sel_xer;
            r_out_unit   <= w_win;
            r_last       <= w_win;
         end else begin
            // Data fields keep their last values; only the valid flag drops.
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.unit_ready = w_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_id     = r_out_id;
   assign bus.out_result = r_out_result;
   assign bus.out_cr     = r_out_cr;
   assign bus.out_xer    = r_out_xer;
   assign bus.out_unit   = r_out_unit;
endmodule
`default_nettype wire

// File: tb/tb_result_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bus_arbiter
// Function : Directed and scoreboarded random checks of result_bus_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_result_bus_arbiter;
   localparam int N  = 8;
   localparam int IW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   result_bus_if #(.NUM_UNITS(N), .RS_ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

   result_bus_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_unit(input int k, input logic [IW-1:0] id, input logic [DW-1:0] res,
                           input logic [3:0] cr, input logic [2:0] xer);
      bus.unit_id[k*IW +: IW]     = id;
      bus.unit_result[k*DW +: DW] = res;
      bus.unit_cr[k*4 +: 4]       = cr;
      bus.unit_xer[k*3 +: 3]      = xer;
   endtask

   logic [39:0] sb_q[$];
   logic [39:0] sb_e;

   // Compare the stage against the scoreboard whenever it drains.
   task automatic sb_drain_check();
      if (bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected", 1, 0);
         end else begin
            sb_e = sb_q.pop_front();
            check("sb_item", {37'(bus.out_unit), bus.out_id, bus.out_result}, 64'(sb_e));
         end
      end
   endtask

   initial begin
      int exp_seq[4];
      exp_seq = '{7, 0, 7, 0};

      rst              = 1'b1;
      bus.unit_valid   = '1;
      bus.out_ready    = 1'b1;
      bus.unit_id      = '0;
      bus.unit_result  = '0;
      bus.unit_cr      = '0;
      bus.unit_xer     = '0;
      for (int k = 0; k < N; k++)
         set_unit(k, 5'(k + 1), 32'hA000_0000 + 32'(k), 4'(k), 3'(k));

      // Reset state, with every unit requesting.
      tick();
      tick();
      #1;
      check("rst_ready", bus.unit_ready, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_id", bus.out_id, 0);
      check("rst_result", bus.out_result, 0);
      check("rst_cr", bus.out_cr, 0);
      check("rst_xer", bus.out_xer, 0);
      check("rst_unit", bus.out_unit, 0);

      // All units requesting: strict rotation 0..7,0 with no bubbles.
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         #1;
         check("rr_ready", bus.unit_ready, 8'h80 >> (i % 8));
         tick();
         check("rr_unit", bus.out_unit, i % 8);
         check("rr_valid", bus.out_valid, 1);
         check("rr_id", bus.out_id, (i % 8) + 1);
      end

      // Single requester unit 2 with specific data.
      bus.unit_valid = 8'b0010_0000;
      set_unit(2, 5'd9, 32'h0000_0042, 4'b0100, 3'b010);
      #1;
      check("u2_ready", bus.unit_ready, 8'b0010_0000);
      tick();
      check("u2_valid", bus.out_valid, 1);
      check("u2_id", bus.out_id, 9);
      check("u2_result", bus.out_result, 32'h42);
      check("u2_cr", bus.out_cr, 4'b0100);
      check("u2_xer", bus.out_xer, 3'b010);
      check("u2_unit", bus.out_unit, 2);

      // Load unit 6 so the pointer sits at 6 before the stall.
      bus.unit_valid = 8'b0000_0010;
      set_unit(6, 5'd20, 32'hDEAD_BEEF, 4'b1000, 3'b100);
      #1;
      check("u6_ready", bus.unit_ready, 8'b0000_0010);
      tick();
      check("u6_unit", bus.out_unit, 6);

      // Stall for 4 cycles with units 1 and 5 requesting.
      bus.out_ready  = 1'b0;
      bus.unit_valid = 8'b0100_0100;
      for (int j = 0; j < 4; j++) begin
         #1;
         check("stall_ready", bus.unit_ready, 0);
         check("stall_valid", bus.out_valid, 1);
         check("stall_unit", bus.out_unit, 6);
         check("stall_id", bus.out_id, 20);
         check("stall_result", bus.out_result, 32'hDEAD_BEEF);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("rel_ready1", bus.unit_ready, 8'b0100_0000);
      tick();
      check("rel_unit1", bus.out_unit, 1);
      #1;
      check("rel_ready5", bus.unit_ready, 8'b0000_0100);
      tick();
      check("rel_unit5", bus.out_unit, 5);

      // No requester while draining: stage empties.
      bus.unit_valid = '0;
      #1;
      check("idle_ready", bus.unit_ready, 0);
      tick();
      check("idle_valid", bus.out_valid, 0);

      // Units 0 and 7 compete: they must alternate.
      bus.unit_valid = 8'b1000_0001;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("alt_ready", bus.unit_ready, 8'h80 >> exp_seq[i]);
         tick();
         check("alt_unit", bus.out_unit, exp_seq[i]);
      end

      // last = 0 and only unit 0 requesting: back-to-back grants to unit 0.
      bus.unit_valid = 8'b1000_0000;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("self_ready", bus.unit_ready, 8'h80);
         tick();
         check("self_unit", bus.out_unit, 0);
         check("self_valid", bus.out_valid, 1);
      end

      // Reset with a full stage; pointer returns to 7 so unit 0 beats unit 3.
      bus.unit_valid = 8'b1001_0000;
      rst = 1'b1;
      #1;
      check("mrst_ready", bus.unit_ready, 0);
      tick();
      check("mrst_valid", bus.out_valid, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", bus.unit_ready, 8'h80);
      tick();
      check("post_rst_unit", bus.out_unit, 0);

      // Flush the directed entry, then random traffic against the scoreboard.
      bus.unit_valid = '0;
      bus.out_ready  = 1'b1;
      tick();
      sb_q.delete();
      for (int c = 0; c < 300; c++) begin
         bus.unit_valid = 8'($urandom);
         bus.out_ready  = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < N; k++)
            set_unit(k, 5'($urandom), $urandom, 4'($urandom), 3'($urandom));
         #1;
         sb_drain_check();
         check("rdy_legal",
               $onehot0(bus.unit_ready) && ((bus.unit_ready & ~bus.unit_valid) == 0), 1);
         for (int k = 0; k < N; k++) begin
            if (bus.unit_ready[k])
               sb_q.push_back({3'(k), bus.unit_id[k*IW +: IW], bus.unit_result[k*DW +: DW]});
         end
         tick();
      end
      bus.unit_valid = '0;
      bus.out_ready  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         sb_drain_check();
         tick();
      end
      check("sb_left", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
